// File: rtl/ffsr_pulse_gen_if.sv
// ffsr_pulse_gen_if: request/pulse bundle between a controller and the pulse generator
interface ffsr_pulse_gen_if #(
    parameter int INPUT_SIZE = 16
);
    logic                  load;
    logic [0:INPUT_SIZE-1] init;
    logic                  start;
    logic [0:INPUT_SIZE-1] target;
    logic                  ready;
    logic                  inc;
    logic                  dec;
    logic                  busy;
    logic                  done;
    logic [0:INPUT_SIZE-1] count;

    modport master (
        output load, init, start, target,
        input  ready, inc, dec, busy, done, count
    );

    modport slave (
        input  load, init, start, target,
        output ready, inc, dec, busy, done, count
    );
endinterface

// File: rtl/ffsr_pulse_gen.sv
// ffsr_pulse_gen: steps an up/down receiver to a target with spaced single-cycle inc/dec pulses
module ffsr_pulse_gen #(
    parameter int INPUT_SIZE = 16,
    parameter int GAP        = 0
) (
    input logic              clk,
    input logic              rst,
    ffsr_pulse_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PULSE, WAIT, DONE} state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP == 0 ? 0 : GAP - 1);

    state_t                state, state_n;
    logic [0:INPUT_SIZE-1] count, count_n, tgt, tgt_n;
    logic [7:0]            wait_cnt, wait_n;
    logic                  inc, dec, busy, done, ready, up;

    // Next state; count moves at the same edge that raises the pulse so it always mirrors the receiver after every issued pulse
    always_comb begin
        state_n = state;
        count_n = count;
        tgt_n   = tgt;
        wait_n  = wait_cnt;
        unique case (state)
            IDLE: begin
                if (bus.load) count_n = bus.init;
                else if (bus.start) begin
                    tgt_n   = bus.target;
                    state_n = bus.target != count ? PULSE : DONE;
                end
            end
            PULSE: begin
                state_n = count == tgt ? DONE : (GAP > 0 ? WAIT : PULSE);
                wait_n  = GAP_LAST;
            end
            WAIT: begin
                wait_n  = wait_cnt - 8'd1;
                state_n = wait_cnt == 8'd0 ? PULSE : WAIT;
            end
            default: state_n = IDLE;
        endcase
        up = tgt_n > count;
        if (state_n == PULSE) count_n = up ? count + 1'b1 : count - 1'b1;
    end

    // State and registered outputs, all derived from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            tgt      <= '0;
            wait_cnt <= '0;
            inc      <= 1'b0;
            dec      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            state    <= state_n;
            count    <= count_n;
            tgt      <= tgt_n;
            wait_cnt <= wait_n;
            inc      <= state_n == PULSE && up;
            dec      <= state_n == PULSE && !up;
            busy     <= state_n == PULSE || state_n == WAIT;
            done     <= state_n == DONE;
            ready    <= state_n == IDLE;
        end
    end

    assign bus.ready = ready;
    assign bus.inc   = inc;
    assign bus.dec   = dec;
    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.count = count;
endmodule

// File: tb/tb_ffsr_pulse_gen.sv
// tb_ffsr_pulse_gen: vectors, directed sequences and random targets against a timing model, for GAP=0 and GAP=2
module tb_ffsr_pulse_gen;
    localparam int W = 6;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   sel = 1'b0;
    logic load_r = 1'b0, start_r = 1'b0;
    logic [W-1:0] init_r = '0, target_r = '0;
    int   checks = 0, errors = 0;
    int   mcnt [2];
    int   rx0 = 0, rx2 = 0;

    always #5 clk = ~clk;

    ffsr_pulse_gen_if #(.INPUT_SIZE(W)) if0 ();
    ffsr_pulse_gen_if #(.INPUT_SIZE(W)) if2 ();

    ffsr_pulse_gen #(.INPUT_SIZE(W), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    ffsr_pulse_gen #(.INPUT_SIZE(W), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.load   = load_r && !sel;
    assign if0.start  = start_r && !sel;
    assign if0.init   = init_r;
    assign if0.target = target_r;
    assign if2.load   = load_r && sel;
    assign if2.start  = start_r && sel;
    assign if2.init   = init_r;
    assign if2.target = target_r;

    logic m_inc, m_dec, m_busy, m_done, m_ready;
    logic [0:W-1] m_count;
    int m_rx;
    assign m_inc   = sel ? if2.inc   : if0.inc;
    assign m_dec   = sel ? if2.dec   : if0.dec;
    assign m_busy  = sel ? if2.busy  : if0.busy;
    assign m_done  = sel ? if2.done  : if0.done;
    assign m_ready = sel ? if2.ready : if0.ready;
    assign m_count = sel ? if2.count : if0.count;
    assign m_rx    = sel ? rx2 : rx0;

    // Receivers: up/down counters loaded alongside the generator and stepped by its pulses
    always @(posedge clk or posedge rst) begin
        if (rst) rx0 <= 0;
        else if (if0.load && if0.ready) rx0 <= int'(if0.init);
        else if (if0.inc) rx0 <= rx0 + 1;
        else if (if0.dec) rx0 <= rx0 - 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) rx2 <= 0;
        else if (if2.load && if2.ready) rx2 <= int'(if2.init);
        else if (if2.inc) rx2 <= rx2 + 1;
        else if (if2.dec) rx2 <= rx2 - 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_load(input bit s, input int v);
        sel = s;
        load_r = 1'b1;
        init_r = W'(v);
        @(negedge clk);
        load_r = 1'b0;
        mcnt[s] = v;
    endtask

    // One operation: expected pulse slots come from distance N and gap g alone
    task automatic op(input bit s, input int t, input bit noise);
        int c, n, g, d, last, mism;
        bit up, ep;
        sel = s;
        c = mcnt[s];
        n = t > c ? t - c : c - t;
        up = t > c;
        g = s ? 2 : 0;
        last = 1 + (n - 1) * (g + 1);
        d = n == 0 ? 1 : last + 1;
        mism = 0;
        target_r = W'(t);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        for (int off = 1; off <= d; off++) begin
            ep = n > 0 && off <= last && (off - 1) % (g + 1) == 0;
            if (m_inc !== (ep && up) || m_dec !== (ep && !up) || m_done !== (off == d)
                || m_busy !== (off < d) || m_ready !== 1'b0) mism++;
            if (noise && off < d) begin
                load_r = 1'($urandom_range(0, 1));
                start_r = 1'($urandom_range(0, 1));
                init_r = W'($urandom);
                target_r = W'($urandom);
            end else begin
                load_r = 1'b0;
                start_r = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("pattern g=%0d %0d->%0d", g, c, t), mism, 0);
        check("ready_after", int'(m_ready), 1);
        check("done_after", int'(m_done), 0);
        check($sformatf("count g=%0d ->%0d", g, t), int'(m_count), t);
        check($sformatf("receiver g=%0d ->%0d", g, t), m_rx, t);
        mcnt[s] = t;
    endtask

    typedef struct {
        logic         load;
        logic [W-1:0] init;
        logic         start;
        logic [W-1:0] target;
        logic         r, b, d;
        logic [W-1:0] cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int bad, saw;
        tbl[0] = '{1'b1, 6'd3,  1'b1, 6'd9,  1'b1, 1'b0, 1'b0, 6'd3};
        tbl[1] = '{1'b0, 6'd0,  1'b1, 6'd3,  1'b0, 1'b0, 1'b1, 6'd3};
        tbl[2] = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd3};
        tbl[3] = '{1'b1, 6'd63, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd63};
        tbl[4] = '{1'b0, 6'd0,  1'b1, 6'd63, 1'b0, 1'b0, 1'b1, 6'd63};
        tbl[5] = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd63};
        tbl[6] = '{1'b1, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd0};
        tbl[7] = '{1'b0, 6'd0,  1'b1, 6'd0,  1'b0, 1'b0, 1'b1, 6'd0};
        tbl[8] = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 6'd0};
        mcnt[0] = 0;
        mcnt[1] = 0;
        repeat (2) @(negedge clk);
        check("rst ready0", int'(if0.ready), 1);
        check("rst busy0", int'(if0.busy), 0);
        check("rst done0", int'(if0.done), 0);
        check("rst pulse0", int'(if0.inc | if0.dec), 0);
        check("rst count0", int'(if0.count), 0);
        check("rst ready2", int'(if2.ready), 1);
        check("rst count2", int'(if2.count), 0);
        rst = 1'b0;
        @(negedge clk);
        op(1'b0, 5, 1'b0);
        do_load(1'b1, 10);
        op(1'b1, 7, 1'b0);
        do_load(1'b0, 4);
        op(1'b0, 4, 1'b0);
        op(1'b1, 20, 1'b1);
        op(1'b0, 30, 1'b1);
        sel = 1'b0;
        for (int i = 0; i < 9; i++) begin
            load_r = tbl[i].load;
            init_r = tbl[i].init;
            start_r = tbl[i].start;
            target_r = tbl[i].target;
            @(negedge clk);
            load_r = 1'b0;
            start_r = 1'b0;
            bad = (m_ready !== tbl[i].r) + (m_busy !== tbl[i].b) + (m_done !== tbl[i].d)
                + ((m_inc | m_dec) !== 1'b0) + (m_count !== tbl[i].cnt);
            check($sformatf("vec%0d", i), bad, 0);
        end
        mcnt[0] = 0;
        op(1'b0, MAXV, 1'b0);
        op(1'b0, 0, 1'b0);
        op(1'b1, MAXV, 1'b0);
        op(1'b1, 0, 1'b0);
        do_load(1'b0, 0);
        target_r = W'(8);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        @(negedge clk);
        check("inc before rst", int'(if0.inc), 1);
        check("count before rst", int'(if0.count), 2);
        #2 rst = 1'b1;
        #1;
        check("abort inc", int'(if0.inc), 0);
        check("abort count", int'(if0.count), 0);
        check("abort ready", int'(if0.ready), 1);
        check("abort busy", int'(if0.busy), 0);
        saw = 0;
        repeat (3) begin
            @(negedge clk);
            saw += int'(if0.done | if0.inc | if0.dec);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw += int'(if0.done | if0.inc | if0.dec);
        end
        check("no activity after abort", saw, 0);
        check("ready after abort", int'(if0.ready), 1);
        mcnt[0] = 0;
        mcnt[1] = 0;
        for (int i = 0; i < 40; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) do_load(s, int'($urandom_range(0, MAXV)));
            op(s, int'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ffsr_pulse_gen.md
FFSR_PULSE_GEN -- requirements
Module: ffsr_pulse_gen

Interface
REQ-001 Parameter: INPUT_SIZE, default 16, width of the count, target and init values.
REQ-002 Parameter: GAP, default 0, number of idle cycles inserted after every pulse (0..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 load  input  1  in IDLE, copies init into the count mirror.
REQ-006 init  input  [0:INPUT_SIZE-1]  value loaded by load; matches the receiver's initial value.
REQ-007 start  input  1  request to drive the receiver to target; accepted only when ready=1.
REQ-008 target  input  [0:INPUT_SIZE-1]  unsigned value to reach; sampled on accept.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 inc  output  1  single-cycle increment pulse to the receiver.
REQ-011 dec  output  1  single-cycle decrement pulse to the receiver.
REQ-012 busy  output  1  high in PULSE and WAIT states.
REQ-013 done  output  1  one-cycle completion strobe.
REQ-014 count  output  [0:INPUT_SIZE-1]  mirror of the receiver value after all issued pulses.

Function
REQ-015 The block SHALL implement the states IDLE, PULSE, WAIT and DONE, with all outputs registered.
REQ-016 In IDLE, load=1 SHALL set count<=init at the clock edge; load SHALL take priority over start in the same cycle, and start SHALL then be ignored.
REQ-017 In IDLE with start=1 and load=0, the block SHALL latch target into an internal register tgt and move to PULSE if tgt!=count, otherwise to DONE.
REQ-018 In PULSE, the block SHALL assert exactly one of inc (tgt>count, unsigned) or dec (tgt<count) for one cycle and update count by +1 or -1 at the same edge.
REQ-019 inc and dec SHALL never be high in the same cycle, and neither SHALL be high outside PULSE.
REQ-020 After a pulse, the block SHALL go to DONE if the updated count equals tgt, else to WAIT if GAP>0, else remain in PULSE.
REQ-021 WAIT SHALL last exactly GAP cycles and then return to PULSE.
REQ-022 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-023 Latency: with start accepted at edge k and distance N=|tgt-count|, pulses SHALL occupy cycles k+1 .. k+1+(N-1)(GAP+1), and done SHALL follow in the next cycle.
REQ-024 With N=0, done SHALL be high in cycle k+1 and no pulse SHALL be issued.
REQ-025 Pulses SHALL only move count toward tgt, so count never wraps; values 0 and 2^INPUT_SIZE-1 SHALL be legal targets.
REQ-026 Outside IDLE, the block SHALL ignore start, load, target and init changes.
REQ-027 Every pulse SHALL be a single-cycle pulse, with at least GAP low cycles between consecutive pulses.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, count=0, tgt=0, inc=0, dec=0, busy=0, done=0 and ready=1.
REQ-029 Reset asserted mid-operation SHALL abort the operation immediately, with no further pulses and no done strobe.
REQ-030 After rst is released, the first rising edge SHALL be a normal IDLE cycle.

Verification
REQ-031 Reset then start with target=5, GAP=0 -> inc high for 5 consecutive cycles, dec never high, done in the 6th cycle, count=5.
REQ-032 load with init=10, then start with target=7, GAP=2 -> 3 dec pulses spaced by 2 low cycles, done after the 3rd pulse, count=7.
REQ-033 count=4, start with target=4 -> done in the cycle after accept, inc=dec=0 throughout.
REQ-034 Assert start, load and target changes while busy -> all ignored, and the original target is still reached.
REQ-035 load and start in the same IDLE cycle (init=3) -> count=3, no operation started, ready stays 1.
REQ-036 Assert rst after 2 of 8 inc pulses -> inc drops immediately, count=0, done never asserted, ready=1.
REQ-037 Connect this block to the ffsr_pulse receiver with matching init, then run random targets -> the receiver out SHALL equal count after every done.
